// File: rtl/alu_cmd_if.sv
// Opcode handshake between the button front end (master) and the ALU (slave).
// The master presents op/op_valid and holds them until op_ready is seen.
interface alu_cmd_if;
    logic       op_valid;
    logic       op_ready;
    logic [1:0] op;
    logic [7:0] op_count;

    modport master (output op_valid, output op, output op_count, input op_ready);
    modport slave  (input op_valid, input op, input op_count, output op_ready);
endinterface

// File: rtl/alu_cmd_issuer.sv
// Debounces two active-low buttons, classifies each gesture (chord / short / long)
// and issues one registered ALU opcode per gesture over a valid/ready handshake.
module alu_cmd_issuer #(
    parameter int unsigned DEBOUNCE_CYCLES = 120000,
    parameter int unsigned CHORD_CYCLES    = 60000,
    parameter int unsigned LONG_CYCLES     = 1200000
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      btn1,
    input  logic      btn2,
    alu_cmd_if.master cmd
);
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TM_W = $clog2(LONG_CYCLES + 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_WIN1     = 3'd1;
    localparam logic [2:0] S_WIN2     = 3'd2;
    localparam logic [2:0] S_HOLD1    = 3'd3;
    localparam logic [2:0] S_ISSUE    = 3'd4;
    localparam logic [2:0] S_WAIT_REL = 3'd5;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    // Bit 0 is btn1, bit 1 is btn2 throughout.
    logic [1:0]      sync0_q, sync0_d, sync1_q, sync1_d;
    logic [1:0]      db_q, db_d;
    logic [DB_W-1:0] db_cnt_q [2];
    logic [DB_W-1:0] db_cnt_d [2];
    logic [1:0]      pr, rl;

    logic [2:0]      state_q, state_d;
    logic [TM_W-1:0] timer_q, timer_d;
    logic [1:0]      op_q, op_d;
    logic [7:0]      cnt_q, cnt_d;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        sync0_d = {btn2, btn1};
        sync1_d = sync0_q;
        for (int b = 0; b < 2; b++) begin
            db_d[b]     = db_q[b];
            db_cnt_d[b] = db_cnt_q[b];
            if (sync1_q[b] == db_q[b]) begin
                db_cnt_d[b] = '0;
            end else if (db_cnt_q[b] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                db_d[b]     = sync1_q[b];
                db_cnt_d[b] = '0;
            end else begin
                db_cnt_d[b] = db_cnt_q[b] + 1'b1;
            end
        end
    end

    // Pulses are taken in the cycle the debounced level is about to flip.
    assign pr = db_q & ~db_d;
    assign rl = ~db_q & db_d;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                timer_d = '0;
                if (pr[0] && pr[1]) begin
                    state_d = S_ISSUE;
                    op_d    = OP_ADD;
                end else if (pr[0]) begin
                    state_d = S_WIN1;
                end else if (pr[1]) begin
                    state_d = S_WIN2;
                end
            end
            S_WIN1: begin
                timer_d = timer_q + 1'b1;
                if (pr[1]) begin
                    state_d = S_ISSUE;
                    op_d    = OP_ADD;
                end else if (rl[0]) begin
                    state_d = S_ISSUE;
                    op_d    = OP_SUB;
                end else if (timer_q == TM_W'(CHORD_CYCLES - 1)) begin
                    state_d = S_HOLD1;
                end
            end
            S_WIN2: begin
                timer_d = timer_q + 1'b1;
                if (pr[0]) begin
                    state_d = S_ISSUE;
                    op_d    = OP_ADD;
                end else if (rl[1] || timer_q == TM_W'(CHORD_CYCLES - 1)) begin
                    state_d = S_ISSUE;
                    op_d    = OP_AND;
                end
            end
            S_HOLD1: begin
                timer_d = timer_q + 1'b1;
                if (rl[0]) begin
                    state_d = S_ISSUE;
                    op_d    = OP_SUB;
                end else if (timer_q == TM_W'(LONG_CYCLES - 1)) begin
                    state_d = S_ISSUE;
                    op_d    = OP_OR;
                end
            end
            S_ISSUE: begin
                if (cmd.op_ready) begin
                    state_d = S_WAIT_REL;
                    cnt_d   = cnt_q + 8'd1;
                end
            end
            S_WAIT_REL: begin
                if (&db_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; the small
    // debounce counter array is reset element by element like any other flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync0_q <= 2'b11;
            sync1_q <= 2'b11;
            db_q    <= 2'b11;
            for (int b = 0; b < 2; b++) db_cnt_q[b] <= '0;
            state_q <= S_IDLE;
            timer_q <= '0;
            op_q    <= OP_ADD;
            cnt_q   <= '0;
        end else begin
            sync0_q <= sync0_d;
            sync1_q <= sync1_d;
            db_q    <= db_d;
            for (int b = 0; b < 2; b++) db_cnt_q[b] <= db_cnt_d[b];
            state_q <= state_d;
            timer_q <= timer_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
        end
    end

    assign cmd.op_valid = (state_q == S_ISSUE);
    assign cmd.op       = op_q;
    assign cmd.op_count = cnt_q;
endmodule
